// File: rtl/tug_playfield_if.sv
// tug_playfield_if: key/light bundle between the tug playfield and its neighbours
// Signals:
//   L, R        raw left/right keys, 1 = pressed, asynchronous to clk
//   resetLight  1 = recentre the light (driven by the scoring block)
//   lights      one-hot LED drive, lights[N_LIGHTS-1] is leftmost
//   LL, RL      leftmost / rightmost LED lit
//   pressL/R    one-cycle pulse per accepted press
// Modports: slave = playfield side, master = keys/scorer side.
interface tug_playfield_if #(
    parameter int N_LIGHTS = 9
);
    logic                L;
    logic                R;
    logic                resetLight;
    logic [N_LIGHTS-1:0] lights;
    logic                LL;
    logic                RL;
    logic                pressL;
    logic                pressR;

    modport slave (
        input  L, R, resetLight,
        output lights, LL, RL, pressL, pressR
    );

    modport master (
        output L, R, resetLight,
        input  lights, LL, RL, pressL, pressR
    );
endinterface

// File: rtl/tug_playfield.sv
// tug_playfield: light-chain playfield for the tug-of-war game
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    tug_playfield_if.slave: L/R/resetLight in; lights/LL/RL/pressL/pressR out
// Optional feature: define TUG_DEBOUNCE_EN to insert a per-key debounce counter between
// the synchroniser and the edge detector (DEBOUNCE_CYCLES stable clks to accept a level).
module tug_playfield #(
    parameter int N_LIGHTS        = 9,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset,
    tug_playfield_if.slave bus
);
    localparam int            PW       = $clog2(N_LIGHTS);
    localparam logic [PW-1:0] CENTRE   = PW'((N_LIGHTS - 1) / 2);
    localparam logic [PW-1:0] LEFT_END = PW'(N_LIGHTS - 1);

    if (N_LIGHTS < 3 || N_LIGHTS % 2 == 0 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("tug_playfield: illegal parameter set");
    end

    // Key vectors are indexed 0 = L, 1 = R.
    logic [1:0]                  key;
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]                  synced;
    logic [SYNC_STAGES-1:0]      ready_q, ready_d;
    logic [1:0]                  lvl;
    logic [1:0]                  armed_q, armed_d;
    logic [1:0]                  prev_q, prev_d;
    logic [1:0]                  press_q, press_d;
    logic [PW-1:0]               pos_q, pos_d;
    logic [N_LIGHTS-1:0]         lights_q, lights_d;
    logic                        ll_q, ll_d;
    logic                        rl_q, rl_d;

    assign key = {bus.R, bus.L};

    always_comb begin
        ready_d = {ready_q[SYNC_STAGES-2:0], 1'b1};
        for (int k = 0; k < 2; k++) begin
            sync_d[k] = {sync_q[k][SYNC_STAGES-2:0], key[k]};
            synced[k] = sync_q[k][SYNC_STAGES-1];
        end
    end

`ifdef TUG_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]         acc_q, acc_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;

    // Count consecutive clks where the synchronised level disagrees with the accepted one;
    // any agreement restarts the count, so short glitches never get through.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            acc_d[k] = acc_q[k];
            cnt_d[k] = '0;
            if (synced[k] != acc_q[k]) begin
                acc_d[k] = (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) ? synced[k] : acc_q[k];
                cnt_d[k] = (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[k] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = acc_q;
`else
    assign lvl = synced;
`endif

    // A key only arms once the synchroniser has refilled after reset and shows it released,
    // so a key held through reset release cannot fake a rising edge.
    always_comb begin
        armed_d = armed_q | (~synced & {2{ready_q[SYNC_STAGES-1]}});
        prev_d  = lvl;
        press_d = lvl & ~prev_q & armed_q;
    end

    // Moves act on the registered pulses; simultaneous presses or a press toward the end
    // already lit hold the light so the scorer can see LL&pressL / RL&pressR.
    always_comb begin
        pos_d    = bus.resetLight                          ? CENTRE :
                   (press_q == 2'b01 && pos_q != LEFT_END) ? pos_q + PW'(1) :
                   (press_q == 2'b10 && pos_q != '0)       ? pos_q - PW'(1) : pos_q;
        lights_d = N_LIGHTS'(1) << pos_d;
        ll_d     = (pos_d == LEFT_END);
        rl_d     = (pos_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            ready_q  <= '0;
            armed_q  <= '0;
            prev_q   <= '0;
            press_q  <= '0;
            pos_q    <= CENTRE;
            lights_q <= N_LIGHTS'(1) << CENTRE;
            ll_q     <= 1'b0;
            rl_q     <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            ready_q  <= ready_d;
            armed_q  <= armed_d;
            prev_q   <= prev_d;
            press_q  <= press_d;
            pos_q    <= pos_d;
            lights_q <= lights_d;
            ll_q     <= ll_d;
            rl_q     <= rl_d;
        end
    end

    assign bus.lights = lights_q;
    assign bus.LL     = ll_q;
    assign bus.RL     = rl_q;
    assign bus.pressL = press_q[0];
    assign bus.pressR = press_q[1];
endmodule

// File: tb/tb_tug_playfield.sv
// tb_tug_playfield: directed self-checking bench for tug_playfield (N_LIGHTS=9, SYNC_STAGES=2)
module tb_tug_playfield;
    localparam int N = 9;
`ifdef TUG_DEBOUNCE_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = LAT + 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tug_playfield_if #(.N_LIGHTS(N)) bus ();

    tug_playfield #(
        .N_LIGHTS(N),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus only: hold the chosen keys, release, and report pulse counts and first-pulse clk.
    task automatic press_keys(input logic l, input logic r, output int nl, output int nr,
                              output int fl, output int fr);
        nl = 0; nr = 0; fl = 0; fr = 0;
        bus.L = l;
        bus.R = r;
        for (int i = 1; i <= 2 * HOLD; i++) begin
            @(negedge clk);
            if (bus.pressL) begin nl++; if (fl == 0) fl = i; end
            if (bus.pressR) begin nr++; if (fr == 0) fr = i; end
            if (i == HOLD) begin bus.L = 1'b0; bus.R = 1'b0; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.L = 1'b0;
        bus.R = 1'b0;
        bus.resetLight = 1'b0;
        idle(2);
        checks++;
        if (bus.lights !== 9'b000010000) begin failures++; $display("FAIL reset_lights got=%b exp=%b", bus.lights, 9'b000010000); end
        checks++;
        if ({bus.LL, bus.RL, bus.pressL, bus.pressR} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.LL, bus.RL, bus.pressL, bus.pressR}); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.lights !== 9'b000010000) begin failures++; $display("FAIL release_lights got=%b exp=%b", bus.lights, 9'b000010000); end
        idle(4);
    endtask

    task automatic test_single_press;
        int n = 0;
        int first = 0;
        bus.L = 1'b1;
        for (int i = 1; i <= 10 + LAT; i++) begin
            @(negedge clk);
            if (bus.pressL) begin n++; if (first == 0) first = i; end
            if (i == LAT + 1) begin
                checks++;
                if (bus.lights !== 9'b000100000) begin failures++; $display("FAIL single_move got=%b exp=%b", bus.lights, 9'b000100000); end
            end
        end
        bus.L = 1'b0;
        checks++;
        if (n !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", n); end
        checks++;
        if (first !== LAT) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", first, LAT); end
        idle(HOLD);
    endtask

    task automatic test_left_end;
        int nl, nr, fl, fr, e;
        bus.resetLight = 1'b1;
        @(negedge clk);
        bus.resetLight = 1'b0;
        checks++;
        if (bus.lights !== 9'b000010000) begin failures++; $display("FAIL recentre got=%b exp=%b", bus.lights, 9'b000010000); end
        for (int p = 1; p <= 5; p++) begin
            press_keys(1'b1, 1'b0, nl, nr, fl, fr);
            e = (4 + p > 8) ? 8 : 4 + p;
            checks++;
            if (nl !== 1 || bus.lights !== (9'b1 << e)) begin failures++; $display("FAIL left_walk%0d got=%b/%0d exp=%b/1", p, bus.lights, nl, 9'b1 << e); end
        end
        checks++;
        if ({bus.LL, bus.RL} !== 2'b10) begin failures++; $display("FAIL left_end_flags got=%b exp=10", {bus.LL, bus.RL}); end
        press_keys(1'b1, 1'b0, nl, nr, fl, fr);
        checks++;
        if (nl !== 1 || bus.lights !== 9'b100000000 || bus.LL !== 1'b1) begin failures++; $display("FAIL left_hold got=%b/%0d/%b exp=100000000/1/1", bus.lights, nl, bus.LL); end
    endtask

    task automatic test_simultaneous;
        int nl, nr, fl, fr;
        press_keys(1'b1, 1'b1, nl, nr, fl, fr);
        checks++;
        if (nl !== 1 || nr !== 1 || fl !== LAT || fr !== LAT) begin failures++; $display("FAIL both_pulses got=%0d@%0d/%0d@%0d exp=1@%0d", nl, fl, nr, fr, LAT); end
        checks++;
        if (bus.lights !== 9'b100000000) begin failures++; $display("FAIL both_hold got=%b exp=%b", bus.lights, 9'b100000000); end
        bus.R = 1'b1;
        idle(LAT);
        checks++;
        if (bus.pressR !== 1'b1) begin failures++; $display("FAIL rl_press got=%b exp=1", bus.pressR); end
        bus.resetLight = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.lights !== 9'b000010000) begin failures++; $display("FAIL rl_override got=%b exp=%b", bus.lights, 9'b000010000); end
        bus.R = 1'b0;
        idle(HOLD);
        press_keys(1'b1, 1'b0, nl, nr, fl, fr);
        checks++;
        if (nl !== 1 || bus.lights !== 9'b000010000) begin failures++; $display("FAIL rl_pinned got=%b/%0d exp=000010000/1", bus.lights, nl); end
        bus.resetLight = 1'b0;
    endtask

    task automatic test_right_end;
        int nl, nr, fl, fr, e;
        for (int p = 1; p <= 5; p++) begin
            press_keys(1'b0, 1'b1, nl, nr, fl, fr);
            e = (4 - p < 0) ? 0 : 4 - p;
            checks++;
            if (nr !== 1 || bus.lights !== (9'b1 << e)) begin failures++; $display("FAIL right_walk%0d got=%b/%0d exp=%b/1", p, bus.lights, nr, 9'b1 << e); end
        end
        checks++;
        if ({bus.LL, bus.RL} !== 2'b01) begin failures++; $display("FAIL right_end_flags got=%b exp=01", {bus.LL, bus.RL}); end
        press_keys(1'b0, 1'b1, nl, nr, fl, fr);
        checks++;
        if (nr !== 1 || bus.lights !== 9'b000000001 || bus.RL !== 1'b1) begin failures++; $display("FAIL right_hold got=%b/%0d/%b exp=000000001/1/1", bus.lights, nr, bus.RL); end
    endtask

    task automatic test_reset_mid_press;
        int nl, nr, fl, fr;
        int n = 0;
        press_keys(1'b1, 1'b0, nl, nr, fl, fr);
        press_keys(1'b1, 1'b0, nl, nr, fl, fr);
        checks++;
        if (bus.lights !== 9'b000000100) begin failures++; $display("FAIL pos2 got=%b exp=%b", bus.lights, 9'b000000100); end
        bus.R = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.lights !== 9'b000010000 || bus.pressR !== 1'b0) begin failures++; $display("FAIL async_reset got=%b/%b exp=000010000/0", bus.lights, bus.pressR); end
        idle(2);
        reset = 1'b1;
        for (int i = 0; i < 3 * HOLD; i++) begin
            @(negedge clk);
            if (bus.pressR) n++;
        end
        checks++;
        if (n !== 0 || bus.RL !== 1'b0 || bus.lights !== 9'b000010000) begin failures++; $display("FAIL held_release got=%0d/%b/%b exp=0/0/000010000", n, bus.RL, bus.lights); end
        bus.R = 1'b0;
        idle(HOLD);
        press_keys(1'b0, 1'b1, nl, nr, fl, fr);
        checks++;
        if (nr !== 1 || bus.lights !== 9'b000001000) begin failures++; $display("FAIL repress got=%b/%0d exp=000001000/1", bus.lights, nr); end
    endtask

`ifdef TUG_DEBOUNCE_EN
    task automatic test_debounce;
        int n = 0;
        int first = 0;
        bus.L = 1'b1;
        idle(10);
        bus.L = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.pressL) n++;
        end
        checks++;
        if (n !== 0) begin failures++; $display("FAIL glitch got=%0d exp=0", n); end
        bus.L = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.pressL) begin n++; if (first == 0) first = i; end
            if (i == 20) bus.L = 1'b0;
        end
        checks++;
        if (n !== 1 || first !== 19) begin failures++; $display("FAIL debounce_press got=%0d@%0d exp=1@19", n, first); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_left_end();
        test_simultaneous();
        test_right_end();
        test_reset_mid_press();
`ifdef TUG_DEBOUNCE_EN
        test_debounce();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
